// File: rtl/axi_mem_arbiter.sv
// Two-master AXI-lite arbiter (IFU fetch, LSU load/store) onto one memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin IFU/LSU arbitration; the default is fixed LSU priority.
module axi_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_arvalid,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    output logic                  ifu_arready,
    output logic                  ifu_rvalid,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,
    input  logic                  ifu_rready,

    input  logic                  lsu_arvalid,
    input  logic [ADDR_W-1:0]     lsu_araddr,
    output logic                  lsu_arready,
    output logic                  lsu_rvalid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    input  logic                  lsu_rready,
    input  logic                  lsu_awvalid,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    output logic                  lsu_awready,
    input  logic                  lsu_wvalid,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_wready,
    output logic                  lsu_bvalid,
    output logic [1:0]            lsu_bresp,
    input  logic                  lsu_bready,

    output logic                  m_arvalid,
    output logic [ADDR_W-1:0]     m_araddr,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    output logic                  m_rready,
    output logic                  m_awvalid,
    output logic [ADDR_W-1:0]     m_awaddr,
    input  logic                  m_awready,
    output logic                  m_wvalid,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_wready,
    input  logic                  m_bvalid,
    input  logic [1:0]            m_bresp,
    output logic                  m_bready,

    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
    typedef enum logic {GNT_IFU, GNT_LSU} grant_t;

    state_t r_state, w_state_nxt;
    grant_t r_grant, w_grant_nxt, r_last_grant;
    logic   r_aw_done, r_w_done, w_aw_done_nxt, w_w_done_nxt;
    logic   w_ifu_req, w_lsu_wr, w_lsu_req, w_lsu_wins, w_leave_idle;
    logic   w_rd_addr, w_rd_data, w_wr_req, w_wr_resp, w_gnt_lsu;

    assign w_ifu_req = ifu_arvalid;
    assign w_lsu_wr  = lsu_awvalid & lsu_wvalid;
    assign w_lsu_req = w_lsu_wr | lsu_arvalid;

`ifdef ARB_ROUND_ROBIN_EN
    // On contention the master that did not win last time goes first.
    assign w_lsu_wins = w_lsu_req & (~w_ifu_req | (r_last_grant == GNT_IFU));
`else
    assign w_lsu_wins = w_lsu_req;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_state)
            IDLE: begin
                if (w_lsu_wins) begin
                    w_grant_nxt = GNT_LSU;
                    w_state_nxt = w_lsu_wr ? WR_REQ : RD_ADDR;
                end else if (w_ifu_req) begin
                    w_grant_nxt = GNT_IFU;
                    w_state_nxt = RD_ADDR;
                end
            end
            RD_ADDR: if (m_arvalid & m_arready) w_state_nxt = RD_DATA;
            RD_DATA: if (m_rvalid & m_rready)   w_state_nxt = IDLE;
            WR_REQ: begin
                w_aw_done_nxt = r_aw_done | (m_awvalid & m_awready);
                w_w_done_nxt  = r_w_done  | (m_wvalid  & m_wready);
                if (w_aw_done_nxt & w_w_done_nxt) begin
                    w_state_nxt   = WR_RESP;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end
            end
            WR_RESP: if (m_bvalid & m_bready)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_leave_idle = (r_state == IDLE) && (w_state_nxt != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= GNT_IFU;
            r_last_grant <= GNT_IFU;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_leave_idle ? w_grant_nxt : r_last_grant;
            r_aw_done    <= w_aw_done_nxt;
            r_w_done     <= w_w_done_nxt;
        end
    end

    assign w_rd_addr = (r_state == RD_ADDR);
    assign w_rd_data = (r_state == RD_DATA);
    assign w_wr_req  = (r_state == WR_REQ);
    assign w_wr_resp = (r_state == WR_RESP);
    assign w_gnt_lsu = (r_grant == GNT_LSU);

    // Read address/data: everything is gated so the idle master sees zeros.
    assign m_arvalid   = w_rd_addr;
    assign m_araddr    = !w_rd_addr ? '0 : (w_gnt_lsu ? lsu_araddr : ifu_araddr);
    assign ifu_arready = w_rd_addr & ~w_gnt_lsu & m_arready;
    assign lsu_arready = w_rd_addr &  w_gnt_lsu & m_arready;

    assign m_rready    = w_rd_data & (w_gnt_lsu ? lsu_rready : ifu_rready);
    assign ifu_rvalid  = w_rd_data & ~w_gnt_lsu & m_rvalid;
    assign ifu_rdata   = (w_rd_data & ~w_gnt_lsu) ? m_rdata : '0;
    assign ifu_rresp   = (w_rd_data & ~w_gnt_lsu) ? m_rresp : '0;
    assign lsu_rvalid  = w_rd_data &  w_gnt_lsu & m_rvalid;
    assign lsu_rdata   = (w_rd_data &  w_gnt_lsu) ? m_rdata : '0;
    assign lsu_rresp   = (w_rd_data &  w_gnt_lsu) ? m_rresp : '0;

    // Writes only ever come from the LSU; AW and W complete independently.
    assign m_awvalid   = w_wr_req & ~r_aw_done;
    assign m_awaddr    = w_wr_req ? lsu_awaddr : '0;
    assign lsu_awready = m_awvalid & m_awready;
    assign m_wvalid    = w_wr_req & ~r_w_done;
    assign m_wdata     = w_wr_req ? lsu_wdata : '0;
    assign m_wstrb     = w_wr_req ? lsu_wstrb : '0;
    assign lsu_wready  = m_wvalid & m_wready;

    assign m_bready    = w_wr_resp & lsu_bready;
    assign lsu_bvalid  = w_wr_resp & m_bvalid;
    assign lsu_bresp   = w_wr_resp ? m_bresp : '0;

    assign busy        = (r_state != IDLE);

endmodule
